// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the Execute stage.
// Runs mult/multu/div/divu as fixed-latency busy windows and owns the
// architectural HI/LO registers. mthi/mtlo write in a single cycle.
// The result is computed when the operation launches and held in the
// pending registers. It is committed to HI/LO when the busy window ends.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous, active-low
//   A, B     - forwarded RS / RT operands
//   md_op    - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   start    - md_op qualifier (the Execute instruction is valid)
//   HI, LO   - architectural HI/LO, valid whenever busy = 0
//   busy     - a mult/div is in progress
//   md_stall - busy | (start & md_op in 1..4), combinational
//
// state  | meaning
// S_IDLE | accepting new md_op; HI/LO are stable and valid
// S_BUSY | count is running down; commit pending result when count hits 0
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  md_op,
    input  logic        start,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        md_stall
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic [31:0]   pending_hi, pending_lo;
    logic          pending_wr;
    logic          is_md, launch, complete, mthi_we, mtlo_we;

    logic [63:0] a_sx, b_sx, prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_mag_safe, b_u_safe;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;

    // Sign-extending both operands to 64 bits makes the low 64 bits of an
    // unsigned product equal to the signed product.
    always_comb begin
        a_sx   = {{32{A[31]}}, A};
        b_sx   = {{32{B[31]}}, B};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, A} * {32'd0, B};

        // Signed division is done on magnitudes and the signs are fixed up
        // afterwards. 0x80000000 / -1 falls out naturally as
        // q = 0x80000000 and r = 0. A zero divisor is replaced by 1 so that
        // the divider never sees zero. That result is discarded anyway.
        a_mag      = A[31] ? (~A + 32'd1) : A;
        b_mag      = B[31] ? (~B + 32'd1) : B;
        b_mag_safe = (B == 32'd0) ? 32'd1 : b_mag;
        b_u_safe   = (B == 32'd0) ? 32'd1 : B;
        q_mag      = a_mag / b_mag_safe;
        r_mag      = a_mag % b_mag_safe;
        q_s        = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s        = A[31] ? (~r_mag + 32'd1) : r_mag;
        q_u        = A / b_u_safe;
        r_u        = A % b_u_safe;

        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
        case (md_op)
            OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_wr = 1'b1; end
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_wr = 1'b1; end
            OP_DIV:   begin res_hi = r_s; res_lo = q_s; res_wr = (B != 32'd0); end
            OP_DIVU:  begin res_hi = r_u; res_lo = q_u; res_wr = (B != 32'd0); end
            default:  ;
        endcase
    end

    assign is_md    = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign busy     = (state == S_BUSY);
    assign md_stall = busy | (start & is_md);

    always_comb begin
        state_next = state;
        count_next = count;
        launch     = 1'b0;
        complete   = 1'b0;
        mthi_we    = 1'b0;
        mtlo_we    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_md) begin
                        launch     = 1'b1;
                        state_next = S_BUSY;
                        count_next = (md_op == OP_MULT || md_op == OP_MULTU)
                                     ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    end else if (md_op == OP_MTHI) begin
                        mthi_we = 1'b1;
                    end else if (md_op == OP_MTLO) begin
                        mtlo_we = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                // Any start while busy is ignored, including mthi/mtlo.
                count_next = count - 1'b1;
                if (count == CW'(1)) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            count      <= '0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            pending_wr <= 1'b0;
            HI         <= 32'd0;
            LO         <= 32'd0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (launch) begin
                pending_hi <= res_hi;
                pending_lo <= res_lo;
                pending_wr <= res_wr;
            end
            if (complete && pending_wr) begin
                HI <= pending_hi;
                LO <= pending_lo;
            end
            if (mthi_we) HI <= A;
            if (mtlo_we) LO <= A;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  md_op;
    logic        start;
    logic [31:0] HI, LO;
    logic        busy, md_stall;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m, lo_m;

    md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .md_op(md_op), .start(start),
        .HI(HI), .LO(LO), .busy(busy), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    // Reference model: wide integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        t  = {hi, lo};
        case (op)
            3'd1: begin q = sa * sb; t = q; end
            3'd2: begin p = ua * ub; t = p; end
            3'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) t = {32'd0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    r = sa - q * sb;
                    t = {r[31:0], q[31:0]};
                end
            end
            3'd4: if (b != 0) begin
                p = ua / ub;
                t[31:0] = p[31:0];
                p = ua % ub;
                t[63:32] = p[31:0];
            end
            default: ;
        endcase
        return t;
    endfunction

    // Called at a negedge (+1). Launches at the next edge T and checks every
    // cycle up to T+N+1. It returns in cycle T+N+1, so a following call
    // launches back-to-back.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject_mt);
        logic [63:0] exp;
        int n;
        exp = ref_md(op, a, b, hi_m, lo_m);
        n = (op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
        start = 1'b1; md_op = op; A = a; B = b;
        #1;
        checks++;
        if (md_stall !== 1'b1) begin
            errors++;
            $display("FAIL launch_stall op=%0d got %b want 1", op, md_stall);
        end
        @(posedge clk);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            start = 1'b0; md_op = 3'd0;
            if (inject_mt && i == 2) begin
                start = 1'b1; md_op = 3'd5; A = 32'h1234;
            end
            #1;
            checks++;
            if (busy !== 1'b1 || md_stall !== 1'b1 || HI !== hi_m || LO !== lo_m) begin
                errors++;
                $display("FAIL busy_window op=%0d cyc=%0d busy=%b stall=%b HI=%h LO=%h want 1 1 %h %h",
                         op, i, busy, md_stall, HI, LO, hi_m, lo_m);
            end
        end
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        #1;
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        checks++;
        if (busy !== 1'b0 || HI !== hi_m || LO !== lo_m) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h busy=%b HI=%h LO=%h want 0 %h %h",
                     op, a, b, busy, HI, LO, hi_m, lo_m);
        end
    endtask

    task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
        start = 1'b1; md_op = op; A = a;
        #1;
        checks++;
        if (md_stall !== 1'b0) begin
            errors++;
            $display("FAIL mt_stall op=%0d got %b want 0", op, md_stall);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        #1;
        if (op == 3'd5) hi_m = a;
        if (op == 3'd6) lo_m = a;
        checks++;
        if (HI !== hi_m || LO !== lo_m || busy !== 1'b0 || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL mt_write op=%0d HI=%h LO=%h busy=%b stall=%b want %h %h 0 0",
                     op, HI, LO, busy, md_stall, hi_m, lo_m);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0 || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_values HI=%h LO=%h busy=%b stall=%b want 0 0 0 0", HI, LO, busy, md_stall);
        end
        start = 1'b1; md_op = 3'd1; #1;
        checks++;
        if (md_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_eq got %b want 1", md_stall);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; md_op = 3'd0; reset = 1'b1; #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_blocks_launch busy=%b want 0", busy);
        end
        // Reset in the middle of a mult discards its result.
        start = 1'b1; md_op = 3'd1; A = 32'hFFFF_FFFE; B = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; md_op = 3'd0; #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_launch busy=%b want 1", busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op HI=%h LO=%h busy=%b want 0 0 0", HI, LO, busy);
        end
        reset = 1'b1;
        repeat (MULT_CYCLES + 3) @(negedge clk);
        #1;
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_late_write HI=%h LO=%h busy=%b want 0 0 0", HI, LO, busy);
        end
        hi_m = 32'd0; lo_m = 32'd0;
    endtask

    task automatic test_directed();
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult_const HI=%h LO=%h want ffffffff fffffffa", HI, LO);
        end
        run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        checks++;
        if (HI !== 32'h0000_0002 || LO !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL multu_const HI=%h LO=%h want 00000002 fffffffa", HI, LO);
        end
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_const HI=%h LO=%h want ffffffff fffffffd", HI, LO);
        end
        run_op(3'd4, 32'd100, 32'd7, 1'b0);
        checks++;
        if (HI !== 32'd2 || LO !== 32'd14) begin
            errors++;
            $display("FAIL divu_const HI=%h LO=%h want 2 14", HI, LO);
        end
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_overflow HI=%h LO=%h want 0 80000000", HI, LO);
        end
    endtask

    task automatic test_div_zero();
        do_mt(3'd5, 32'h11);
        do_mt(3'd6, 32'h22);
        run_op(3'd4, 32'd7, 32'd0, 1'b0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd0, 1'b0);
        checks++;
        if (HI !== 32'h11 || LO !== 32'h22) begin
            errors++;
            $display("FAIL div_zero HI=%h LO=%h want 11 22", HI, LO);
        end
    endtask

    task automatic test_mt_busy();
        run_op(3'd4, 32'd100, 32'd7, 1'b1);
        checks++;
        if (HI !== 32'd2) begin
            errors++;
            $display("FAIL mthi_during_busy HI=%h want 2", HI);
        end
        run_op(3'd1, 32'd6, 32'd7, 1'b1);
        do_mt(3'd5, 32'h1234);
        checks++;
        if (HI !== 32'h1234 || LO !== 32'd42) begin
            errors++;
            $display("FAIL mthi_after_busy HI=%h LO=%h want 1234 2a", HI, LO);
        end
    endtask

    task automatic test_ignored_ops();
        logic [2:0] ops [2];
        ops[0] = 3'd0; ops[1] = 3'd7;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; md_op = ops[k]; A = $urandom; B = $urandom; #1;
            checks++;
            if (md_stall !== 1'b0) begin
                errors++;
                $display("FAIL noop_stall op=%0d got %b want 0", ops[k], md_stall);
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0; md_op = 3'd0; #1;
            checks++;
            if (HI !== hi_m || LO !== lo_m || busy !== 1'b0) begin
                errors++;
                $display("FAIL noop_effect op=%0d HI=%h LO=%h busy=%b want %h %h 0",
                         ops[k], HI, LO, busy, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_op(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        run_op(3'd3, 32'd9, 32'hFFFF_FFFC, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(1, 6));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            if (op >= 3'd5) do_mt(op, a);
            else run_op(op, a, b, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        hi_m = 32'd0; lo_m = 32'd0;
        test_reset();
        test_directed();
        test_div_zero();
        test_mt_busy();
        test_ignored_ops();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
